// File: rtl/wb_tag_pipeline_pkg.sv
// Shared types for the writeback tag pipeline: register index width, per-stage tag record
// and the bubble constant loaded on stall or flush.
package wb_tag_pipeline_pkg;

    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              valid;
    } stage_tag_t;

    localparam stage_tag_t BUBBLE_TAG = '{
        rs1:      '0,
        rs2:      '0,
        rd:       '0,
        regwrite: 1'b0,
        memread:  1'b0,
        valid:    1'b0
    };

endpackage

// File: rtl/wb_tag_pipeline_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands of the instruction in ID.
// A taken branch/jump in EX suppresses the stall so the redirect can load.
module wb_tag_pipeline_hazard_detect
    import wb_tag_pipeline_pkg::*;
#(
    parameter int unsigned RegAw = REG_AW
) (
    input  logic             ex_memread_i,
    input  logic [RegAw-1:0] ex_rd_i,
    input  logic [RegAw-1:0] id_rs1_i,
    input  logic [RegAw-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             flush_i,
    output logic             stall_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 loads produce no value worth waiting for.
    assign stall_o = ex_memread_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit) && !flush_i;

endmodule

// File: rtl/wb_tag_pipeline.sv
// Destination-tag pipeline ID->EX->MEM->WB feeding the forwarding unit, plus load-use stall
// control for IF/ID. Optional statistics counters are enabled with WB_TAG_STATS_EN.
module wb_tag_pipeline #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_UseRS1,
    input  logic              ID_UseRS2,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              Flush_i,
    output logic [REG_AW-1:0] IDEXE_RS1,
    output logic [REG_AW-1:0] IDEXE_RS2,
    output logic              IDEXE_MemRead,
    output logic [REG_AW-1:0] EXEMEM_RD,
    output logic              EXEMEM_RegWrite,
    output logic [REG_AW-1:0] MEMWB_RD,
    output logic              MEMWB_RegWrite,
    output logic              Stall_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o
`ifdef WB_TAG_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] StallCnt_o,
    output logic [STALL_CNT_W-1:0] FlushCnt_o,
    output logic [STALL_CNT_W-1:0] RetireCnt_o
`endif
);

    import wb_tag_pipeline_pkg::stage_tag_t;
    import wb_tag_pipeline_pkg::BUBBLE_TAG;

    stage_tag_t        ex_q, ex_d;
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_regwrite_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic              wb_regwrite_q;
    logic              stall;

    wb_tag_pipeline_hazard_detect #(
        .RegAw (REG_AW)
    ) u_hazard_detect (
        .ex_memread_i (ex_q.memread),
        .ex_rd_i      (ex_q.rd),
        .id_rs1_i     (ID_RS1),
        .id_rs2_i     (ID_RS2),
        .id_use_rs1_i (ID_UseRS1),
        .id_use_rs2_i (ID_UseRS2),
        .flush_i      (Flush_i),
        .stall_o      (stall)
    );

    // Unused operands are zeroed so a stale index never matches a producer downstream.
    always_comb begin
        ex_d = BUBBLE_TAG;
        if (!(stall || Flush_i)) begin
            ex_d.rs1      = ID_UseRS1 ? ID_RS1 : '0;
            ex_d.rs2      = ID_UseRS2 ? ID_RS2 : '0;
            ex_d.rd       = ID_RD;
            ex_d.regwrite = ID_RegWrite;
            ex_d.memread  = ID_MemRead;
`ifdef WB_TAG_STATS_EN
            ex_d.valid    = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q           <= BUBBLE_TAG;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
        end else begin
            ex_q           <= ex_d;
            mem_rd_q       <= ex_q.rd;
            mem_regwrite_q <= ex_q.regwrite;
            wb_rd_q        <= mem_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
        end
    end

    assign IDEXE_RS1       = ex_q.rs1;
    assign IDEXE_RS2       = ex_q.rs2;
    assign IDEXE_MemRead   = ex_q.memread;
    assign EXEMEM_RD       = mem_rd_q;
    assign EXEMEM_RegWrite = mem_regwrite_q;
    assign MEMWB_RD        = wb_rd_q;
    assign MEMWB_RegWrite  = wb_regwrite_q;
    assign Stall_o         = stall;
    assign PCWrite_o       = !stall;
    assign IFIDWrite_o     = !stall;

`ifdef WB_TAG_STATS_EN
    localparam logic [STALL_CNT_W-1:0] CntMax = '1;
    localparam logic [STALL_CNT_W-1:0] CntOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic                   mem_valid_q;
    logic                   wb_valid_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STALL_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [STALL_CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (stall && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        if (Flush_i && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CntOne;
        end
        if (wb_valid_q && (retire_cnt_q != CntMax)) begin
            retire_cnt_d = retire_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_valid_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            mem_valid_q  <= ex_q.valid;
            wb_valid_q   <= mem_valid_q;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign StallCnt_o  = stall_cnt_q;
    assign FlushCnt_o  = flush_cnt_q;
    assign RetireCnt_o = retire_cnt_q;
`else
    // Valid bit is tied low and the counter width is meaningless without statistics.
    logic unused_ok;
    assign unused_ok = ex_q.valid ^ (STALL_CNT_W == 0);
`endif

endmodule

// File: tb/tb_wb_tag_pipeline.sv
// Directed, table-driven bench for wb_tag_pipeline; statistics checks follow WB_TAG_STATS_EN.
module tb_wb_tag_pipeline;

    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 5;
    localparam int          NV    = 20;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] ID_RS1, ID_RS2, ID_RD;
    logic          ID_UseRS1, ID_UseRS2, ID_RegWrite, ID_MemRead, Flush_i;
    logic [AW-1:0] IDEXE_RS1, IDEXE_RS2, EXEMEM_RD, MEMWB_RD;
    logic          IDEXE_MemRead, EXEMEM_RegWrite, MEMWB_RegWrite;
    logic          Stall_o, PCWrite_o, IFIDWrite_o;
`ifdef WB_TAG_STATS_EN
    logic [CNT_W-1:0] StallCnt_o, FlushCnt_o, RetireCnt_o;
`endif

    wb_tag_pipeline #(
        .REG_AW      (AW),
        .STALL_CNT_W (CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ID_RS1          (ID_RS1),
        .ID_RS2          (ID_RS2),
        .ID_RD           (ID_RD),
        .ID_UseRS1       (ID_UseRS1),
        .ID_UseRS2       (ID_UseRS2),
        .ID_RegWrite     (ID_RegWrite),
        .ID_MemRead      (ID_MemRead),
        .Flush_i         (Flush_i),
        .IDEXE_RS1       (IDEXE_RS1),
        .IDEXE_RS2       (IDEXE_RS2),
        .IDEXE_MemRead   (IDEXE_MemRead),
        .EXEMEM_RD       (EXEMEM_RD),
        .EXEMEM_RegWrite (EXEMEM_RegWrite),
        .MEMWB_RD        (MEMWB_RD),
        .MEMWB_RegWrite  (MEMWB_RegWrite),
        .Stall_o         (Stall_o),
        .PCWrite_o       (PCWrite_o),
        .IFIDWrite_o     (IFIDWrite_o)
`ifdef WB_TAG_STATS_EN
        ,
        .StallCnt_o      (StallCnt_o),
        .FlushCnt_o      (FlushCnt_o),
        .RetireCnt_o     (RetireCnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] rs1, rs2, rd;
        logic          u1, u2, rw, mr, fl;
        logic          st;
        logic [AW-1:0] e_rs1, e_rs2;
        logic          e_mr;
        logic [AW-1:0] m_rd;
        logic          m_rw;
        logic [AW-1:0] w_rd;
        logic          w_rw;
    } vec_t;

    vec_t vecs [NV];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic u1, input logic u2,
                         input logic rw, input logic mr, input logic fl);
        ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd;
        ID_UseRS1 = u1; ID_UseRS2 = u2; ID_RegWrite = rw; ID_MemRead = mr; Flush_i = fl;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " idexe_rs1"}, 32'(IDEXE_RS1), 0);
        chk({tag, " idexe_rs2"}, 32'(IDEXE_RS2), 0);
        chk({tag, " idexe_mr"}, 32'(IDEXE_MemRead), 0);
        chk({tag, " exemem_rd"}, 32'(EXEMEM_RD), 0);
        chk({tag, " exemem_rw"}, 32'(EXEMEM_RegWrite), 0);
        chk({tag, " memwb_rd"}, 32'(MEMWB_RD), 0);
        chk({tag, " memwb_rw"}, 32'(MEMWB_RegWrite), 0);
        chk({tag, " stall"}, 32'(Stall_o), 0);
        chk({tag, " pcwrite"}, 32'(PCWrite_o), 1);
        chk({tag, " ifidwrite"}, 32'(IFIDWrite_o), 1);
    endtask

    initial begin
        // rs1 rs2 rd u1 u2 rw mr fl | st | ex rs1 rs2 mr | mem rd rw | wb rd rw
        vecs[0]  = '{1, 2, 5, 1, 1, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0};   // add x5
        vecs[1]  = '{3, 4, 6, 1, 1, 1, 0, 0, 0, 3, 4, 0, 5, 1, 0, 0};   // add x6
        vecs[2]  = '{5, 0, 7, 1, 0, 1, 1, 0, 0, 5, 0, 1, 6, 1, 5, 1};   // lw x7
        vecs[3]  = '{7, 1, 8, 1, 1, 1, 0, 0, 1, 0, 0, 0, 7, 1, 6, 1};   // add uses x7: stall
        vecs[4]  = '{7, 1, 8, 1, 1, 1, 0, 0, 0, 7, 1, 0, 0, 0, 7, 1};   // held add enters EX
        vecs[5]  = '{2, 0, 0, 1, 0, 1, 1, 0, 0, 2, 0, 1, 8, 1, 0, 0};   // lw x0
        vecs[6]  = '{0, 0, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 8, 1};   // uses x0: no stall
        vecs[7]  = '{1, 0, 3, 1, 0, 1, 1, 0, 0, 1, 0, 1, 9, 1, 0, 1};   // lw x3
        vecs[8]  = '{4, 3, 10, 1, 0, 1, 0, 0, 0, 4, 0, 0, 3, 1, 9, 1};  // rs2=3 unused
        vecs[9]  = '{2, 0, 7, 1, 0, 1, 1, 0, 0, 2, 0, 1, 10, 1, 3, 1};  // lw x7
        vecs[10] = '{1, 7, 11, 1, 1, 1, 0, 1, 0, 0, 0, 0, 7, 1, 10, 1}; // consumer + flush
        vecs[11] = '{1, 0, 12, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 7, 1};  // lw x12
        vecs[12] = '{12, 0, 13, 1, 0, 1, 1, 0, 1, 0, 0, 0, 12, 1, 0, 0}; // lw x13,(x12)
        vecs[13] = '{12, 0, 13, 1, 0, 1, 1, 0, 0, 12, 0, 1, 0, 0, 12, 1};
        vecs[14] = '{13, 0, 14, 1, 0, 1, 1, 0, 1, 0, 0, 0, 13, 1, 0, 0}; // lw x14,(x13)
        vecs[15] = '{13, 0, 14, 1, 0, 1, 1, 0, 0, 13, 0, 1, 0, 0, 13, 1};
        vecs[16] = '{2, 14, 15, 1, 1, 1, 0, 0, 1, 0, 0, 0, 14, 1, 0, 0}; // rs2 hit
        vecs[17] = '{2, 14, 15, 1, 1, 1, 0, 0, 0, 2, 14, 0, 0, 0, 14, 1};
        vecs[18] = '{5, 6, 16, 1, 1, 1, 0, 1, 0, 0, 0, 0, 15, 1, 0, 0}; // plain flush
        vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 1};

        // Reset held for three edges with random ID traffic.
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            chk_cleared($sformatf("reset c%0d", c));
            tick();
        end
        chk_cleared("reset end");
        rst_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                  vecs[i].rw, vecs[i].mr, vecs[i].fl);
            #1;
            chk($sformatf("v%0d stall", i), 32'(Stall_o), 32'(vecs[i].st));
            chk($sformatf("v%0d pcwrite", i), 32'(PCWrite_o), 32'(!vecs[i].st));
            chk($sformatf("v%0d ifidwrite", i), 32'(IFIDWrite_o), 32'(!vecs[i].st));
            tick();
            chk($sformatf("v%0d idexe_rs1", i), 32'(IDEXE_RS1), 32'(vecs[i].e_rs1));
            chk($sformatf("v%0d idexe_rs2", i), 32'(IDEXE_RS2), 32'(vecs[i].e_rs2));
            chk($sformatf("v%0d idexe_mr", i), 32'(IDEXE_MemRead), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d exemem_rd", i), 32'(EXEMEM_RD), 32'(vecs[i].m_rd));
            chk($sformatf("v%0d exemem_rw", i), 32'(EXEMEM_RegWrite), 32'(vecs[i].m_rw));
            chk($sformatf("v%0d memwb_rd", i), 32'(MEMWB_RD), 32'(vecs[i].w_rd));
            chk($sformatf("v%0d memwb_rw", i), 32'(MEMWB_RegWrite), 32'(vecs[i].w_rw));
        end

        // Asynchronous reset mid-operation, with a pending load-use hazard.
        drive(1, 2, 5, 1, 1, 1, 0, 0);
        tick();
        drive(5, 0, 7, 1, 0, 1, 1, 0);
        tick();
        drive(7, 0, 8, 1, 0, 1, 0, 0);
        #1;
        chk("midrst pre stall", 32'(Stall_o), 1);
        chk("midrst pre exemem_rd", 32'(EXEMEM_RD), 5);
        rst_i = 1'b0;
        #1;
        chk_cleared("midrst async");
        tick();
        chk_cleared("midrst held");
        rst_i = 1'b1;

`ifdef WB_TAG_STATS_EN
        chk("stats reset stall_cnt", 32'(StallCnt_o), 0);
        chk("stats reset flush_cnt", 32'(FlushCnt_o), 0);
        chk("stats reset retire_cnt", 32'(RetireCnt_o), 0);
        // 30 cycles: four load-use pairs, two flushes, idle tail.
        for (int p = 0; p < 4; p++) begin
            drive(1, 0, 7, 1, 0, 1, 1, 0);
            tick();
            drive(7, 2, 8, 1, 1, 1, 0, 0);
            #1;
            chk($sformatf("stats pair%0d stall", p), 32'(Stall_o), 1);
            tick();
            tick();
        end
        drive(5, 6, 9, 1, 1, 1, 0, 1);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (16) tick();
        chk("stats stall_cnt", 32'(StallCnt_o), 4);
        chk("stats flush_cnt", 32'(FlushCnt_o), 2);
        chk("stats retire_cnt", 32'(RetireCnt_o), 21);

        // Drive the counters past all-ones.
        drive(1, 0, 7, 1, 0, 1, 1, 0);
        tick();
        drive(7, 0, 7, 1, 0, 1, 1, 0);
        repeat (30) begin
            tick();
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (30) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("stats sat stall_cnt", 32'(StallCnt_o), 32'((1 << CNT_W) - 1));
        chk("stats sat flush_cnt", 32'(FlushCnt_o), 32'((1 << CNT_W) - 1));
        chk("stats sat retire_cnt", 32'(RetireCnt_o), 32'((1 << CNT_W) - 1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_tag_pipeline.md
Name: wb_tag_pipeline

Overview:
- Producer side of the bypass interface: carries each instruction's destination tag (rd, RegWrite, MemRead) from ID through EX, MEM and WB.
- Drives the IDEXE/EXEMEM/MEMWB tag signals that the forwarding logic consumes.
- Detects load-use hazards and issues the stall/bubble controls for IF/ID.
- Sits beside the datapath pipeline registers in the 5-stage core; it owns tags only, no data.

Parameters:
REG_AW, 5, register index width
STALL_CNT_W, 16, width of statistics counters (used only with the optional feature)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-low reset
ID_RS1  in  REG_AW  rs1 index of the instruction in ID
ID_RS2  in  REG_AW  rs2 index of the instruction in ID
ID_RD  in  REG_AW  rd index of the instruction in ID
ID_UseRS1  in  1  ID instruction reads rs1
ID_UseRS2  in  1  ID instruction reads rs2
ID_RegWrite  in  1  ID instruction writes rd
ID_MemRead  in  1  ID instruction is a load
Flush_i  in  1  branch/jump resolved taken in EX: kill the ID instruction
IDEXE_RS1  out  REG_AW  EX-stage rs1 tag
IDEXE_RS2  out  REG_AW  EX-stage rs2 tag
IDEXE_MemRead  out  1  EX-stage load flag
EXEMEM_RD  out  REG_AW  MEM-stage rd tag
EXEMEM_RegWrite  out  1  MEM-stage write enable
MEMWB_RD  out  REG_AW  WB-stage rd tag
MEMWB_RegWrite  out  1  WB-stage write enable (also the regfile write enable)
Stall_o  out  1  load-use hazard this cycle
PCWrite_o  out  1  PC update enable (~Stall_o)
IFIDWrite_o  out  1  IF/ID register enable (~Stall_o)

Behaviour:
- Reset (rst_i low, async):
  - all stage registers clear: RS1/RS2/RD = 0, RegWrite = 0, MemRead = 0.
  - Stall_o = 0, PCWrite_o = 1, IFIDWrite_o = 1.
  - Reset mid-operation discards every in-flight tag.
- EX stage holds RS1, RS2, RD, RegWrite, MemRead.
  - ID_UseRSx = 0 loads 0 into the EX RSx tag, so x0 never triggers a forward.
- Stall_o (combinational) = EX.MemRead & (EX.RD != 0) & ((ID_UseRS1 & ID_RS1 == EX.RD) | (ID_UseRS2 & ID_RS2 == EX.RD)) & ~Flush_i.
- Per rising edge:
  - MEM <= EX (RD, RegWrite); WB <= MEM. These two always advance and are never stalled.
  - EX <= bubble (all fields 0) if Stall_o or Flush_i; otherwise EX <= ID fields.
- Flush and stall in the same cycle: flush wins, Stall_o = 0, and PC/IF-ID update normally so the redirect can load.
- A load with rd = x0 never stalls.
- Load-use latency: exactly one bubble. In the next cycle the load is in MEM, and the consumer later forwards from MEMWB.
- Back-to-back loads into dependent loads: each pair stalls once, with no cumulative extra stall.
- Outputs are registered stage contents; the only combinational outputs are Stall_o, PCWrite_o and IFIDWrite_o.
- Same-cycle WB write and ID read of the same register is resolved by the register file (write-first). No stall is generated for it.

Optional Feature:
- Macro: WB_TAG_STATS_EN.
- When defined, adds outputs:
  - StallCnt_o [STALL_CNT_W]: cycles with Stall_o = 1.
  - FlushCnt_o [STALL_CNT_W]: cycles with Flush_i = 1.
  - RetireCnt_o [STALL_CNT_W]: cycles with a non-bubble instruction in WB, tracked by a per-stage valid bit.
- Counter rules: clear on reset, saturate at all-ones, no wrap.
- When not defined: the ports, valid bits and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - REG_AW.
  - Stage-tag struct {rs1, rs2, rd, regwrite, memread, valid}.
  - BUBBLE_TAG constant.
- Sub-module: hazard_detect, the combinational load-use compare that produces Stall_o.
- Stage registers stay in the top.

Test Plan:
- Reset: hold rst_i low 3 cycles with random inputs -> all tags 0, Stall_o = 0, PCWrite_o = 1 throughout; release -> first ID instruction appears on IDEXE_RS1 after one edge.
- Tag flow: issue add x5 (RegWrite=1) -> EXEMEM_RD = 5 / EXEMEM_RegWrite = 1 two edges later, MEMWB_RD = 5 three edges later.
- Load-use: lw x7 then add rs1=x7 -> Stall_o = 1 for exactly one cycle, EX becomes bubble, add enters EX next cycle; lw rd=x0 followed by a consumer of x0 -> no stall.
- Flush priority: lw x7 in EX, ID consumer of x7 with Flush_i = 1 -> Stall_o = 0, EX = bubble, PCWrite_o = 1.
- Unused operand: lw x3 then instruction with ID_RS2 = 3, ID_UseRS2 = 0 -> no stall, IDEXE_RS2 = 0.
- WB_TAG_STATS_EN: 4 load-use pairs plus 2 flushes over 30 cycles -> StallCnt_o = 4, FlushCnt_o = 2; force 2^16 stalls -> StallCnt_o holds at 0xFFFF.
